// File: rtl/arm7tdmi_decode_checker_pkg.sv
// arm7tdmi_decode_checker_pkg: shared types and constants for the decode-stage checker.
package arm7tdmi_decode_checker_pkg;
  localparam int CHECKER_TYPE_W = 5;
  typedef enum logic [1:0] {
    CHK_PASS       = 2'd0,
    CHK_FAIL_TYPE  = 2'd1,
    CHK_FAIL_MODE  = 2'd2,
    CHK_UNEXPECTED = 2'd3
  } checker_result_t;
endpackage

// File: rtl/arm7tdmi_decode_checker_if.sv
// arm7tdmi_decode_checker_if: expected-entry push and observed-decode buses.
interface arm7tdmi_decode_checker_if import arm7tdmi_decode_checker_pkg::*; #(
  parameter int TYPE_W = CHECKER_TYPE_W
);
  logic              exp_valid, exp_ready, exp_thumb;
  logic              obs_valid, obs_thumb;
  logic [TYPE_W-1:0] exp_type, obs_type;
  modport master (output exp_valid, exp_type, exp_thumb, obs_valid, obs_type, obs_thumb, input exp_ready);
  modport slave  (input exp_valid, exp_type, exp_thumb, obs_valid, obs_type, obs_thumb, output exp_ready);
endinterface

// File: rtl/arm7tdmi_decode_checker_sync_fifo.sv
// arm7tdmi_decode_checker_sync_fifo: synchronous FIFO with wrap-bit pointers and level output.
module arm7tdmi_decode_checker_sync_fifo #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;
  assign level   = wr_q - rd_q;
  assign full    = level == (AW+1)'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = clear ? '0 : do_push ? wr_q + 1'b1 : wr_q;
    rd_d = clear ? '0 : do_pop ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/arm7tdmi_decode_checker.sv
// arm7tdmi_decode_checker: in-order scoreboard for decode results with coverage and statistics.
// ARM7TDMI_CHECKER_FIRST_FAIL_EN builds the first-failure capture registers.
module arm7tdmi_decode_checker import arm7tdmi_decode_checker_pkg::*; #(
  parameter  int TYPE_W      = CHECKER_TYPE_W,
  parameter  int NUM_CLASSES = 16,
  parameter  int DEPTH       = 8,
  parameter  int CNT_W       = 16,
  localparam int LW          = $clog2(DEPTH) + 1,
  localparam int CW          = $clog2(NUM_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  arm7tdmi_decode_checker_if.slave bus,
  output logic                 mismatch,
  output checker_result_t      result,
  output logic [LW-1:0]        fifo_level,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CNT_W-1:0]     unexp_count,
  output logic [CNT_W-1:0]     arm_count,
  output logic [CNT_W-1:0]     thumb_count,
  input  logic [CW-1:0]        rd_sel,
  input  logic                 rd_thumb,
  output logic [CNT_W-1:0]     rd_hits,
  output logic                 all_pass,
  output logic [TYPE_W-1:0]    first_fail_exp,
  output logic [TYPE_W-1:0]    first_fail_got,
  output logic [CNT_W-1:0]     first_fail_idx
);
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction
  logic              empty, full, head_thumb, chk, fail;
  logic [TYPE_W-1:0] head_type;
  logic [CW-1:0]     bin_idx;
  checker_result_t   res_d, result_q;
  logic              mismatch_q;
  logic [CNT_W-1:0]  pass_q, fail_q, unexp_q, arm_q, thumb_q;
  logic [CNT_W-1:0]  pass_d, fail_d, unexp_d, arm_d, thumb_d;
  logic [CNT_W-1:0]  bins_q [2][NUM_CLASSES];
  arm7tdmi_decode_checker_sync_fifo #(.WIDTH(TYPE_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (bus.exp_valid),
    .pop   (bus.obs_valid),
    .wdata ({bus.exp_thumb, bus.exp_type}),
    .rdata ({head_thumb, head_type}),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );
  assign bus.exp_ready = !full;
  assign chk     = bus.obs_valid && !clear;
  assign fail    = chk && res_d != CHK_PASS;
  assign bin_idx = (32'(bus.obs_type) >= NUM_CLASSES) ? CW'(NUM_CLASSES - 1) : CW'(bus.obs_type);
  always_comb begin
    res_d   = empty ? CHK_UNEXPECTED : head_thumb != bus.obs_thumb ? CHK_FAIL_MODE :
              head_type != bus.obs_type ? CHK_FAIL_TYPE : CHK_PASS;
    pass_d  = inc(pass_q, chk && res_d == CHK_PASS);
    fail_d  = inc(fail_q, fail);
    unexp_d = inc(unexp_q, chk && res_d == CHK_UNEXPECTED);
    arm_d   = inc(arm_q, chk && !bus.obs_thumb);
    thumb_d = inc(thumb_q, chk && bus.obs_thumb);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {pass_q, fail_q, unexp_q, arm_q, thumb_q} <= '0;
      mismatch_q <= 1'b0;
      result_q   <= CHK_PASS;
    end else if (clear) begin
      {pass_q, fail_q, unexp_q, arm_q, thumb_q} <= '0;
      mismatch_q <= 1'b0;
      result_q   <= CHK_PASS;
    end else begin
      {pass_q, fail_q, unexp_q, arm_q, thumb_q} <= {pass_d, fail_d, unexp_d, arm_d, thumb_d};
      mismatch_q <= fail;
      result_q   <= chk ? res_d : result_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) for (int c = 0; c < NUM_CLASSES; c++) bins_q[b][c] <= '0;
    end else if (clear) begin
      for (int b = 0; b < 2; b++) for (int c = 0; c < NUM_CLASSES; c++) bins_q[b][c] <= '0;
    end else if (chk) begin
      bins_q[bus.obs_thumb][bin_idx] <= inc(bins_q[bus.obs_thumb][bin_idx], 1'b1);
    end
  end
  assign mismatch    = mismatch_q;
  assign result      = result_q;
  assign pass_count  = pass_q;
  assign fail_count  = fail_q;
  assign unexp_count = unexp_q;
  assign arm_count   = arm_q;
  assign thumb_count = thumb_q;
  assign rd_hits     = bins_q[rd_thumb][rd_sel];
  assign all_pass    = fail_q == '0 && pass_q != '0 && empty;
`ifdef ARM7TDMI_CHECKER_FIRST_FAIL_EN
  logic              ff_seen_q;
  logic [TYPE_W-1:0] ff_exp_q, ff_got_q;
  logic [CNT_W-1:0]  ff_idx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ff_seen_q, ff_exp_q, ff_got_q, ff_idx_q} <= '0;
    end else if (clear) begin
      {ff_seen_q, ff_exp_q, ff_got_q, ff_idx_q} <= '0;
    end else if (fail && !ff_seen_q) begin
      ff_seen_q <= 1'b1;
      ff_exp_q  <= res_d == CHK_UNEXPECTED ? '0 : head_type;
      ff_got_q  <= bus.obs_type;
      ff_idx_q  <= pass_q + fail_q;
    end
  end
  assign first_fail_exp = ff_exp_q;
  assign first_fail_got = ff_got_q;
  assign first_fail_idx = ff_idx_q;
`else
  assign first_fail_exp = '0;
  assign first_fail_got = '0;
  assign first_fail_idx = '0;
`endif
endmodule
